serial_comparator: RTL and testbench

- Bit-serial magnitude comparator: the receiving end of a serial operand link.
- Accepts two WIDTH-bit operands A and B one bit pair per beat, MSB first.
- Produces the same flags as the parallel comparator: ZF (A==B), SLTu (A<B unsigned) and SLT (A<B two's-complement signed).
- Used where operands arrive over a serializer and a parallel compare would need a deserializer first.

---
 rtl/serial_comparator.sv | 117 +++++++++++
 tb/tb_serial_comparator.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/serial_comparator.sv
// Bit-serial magnitude comparator: consumes A/B one bit pair per accepted beat, MSB first,
// and reports A==B, A<B unsigned and A<B signed once all WIDTH beats have arrived.
module serial_comparator #(
  parameter int unsigned WIDTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic bit_valid,
  input  logic a_bit,
  input  logic b_bit,
  output logic busy,
  output logic done,
  output logic ZF,
  output logic SLTu,
  output logic SLT
);

  localparam int unsigned CntW = $clog2(WIDTH) + 1;
  localparam logic [CntW-1:0] LastBeat = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            eq_q, eq_d;
  logic            ltu_q, ltu_d;
  logic            msb_a_q, msb_a_d;
  logic            msb_b_q, msb_b_d;
  logic            zf_q, zf_d;
  logic            sltu_q, sltu_d;
  logic            slt_q, slt_d;

  // The first differing bit pair (from the MSB) decides the unsigned order.
  logic eq_new, ltu_new;
  always_comb begin
    eq_new  = eq_q;
    ltu_new = ltu_q;
    if (eq_q && (a_bit != b_bit)) begin
      eq_new  = 1'b0;
      ltu_new = ~a_bit & b_bit;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    eq_d    = eq_q;
    ltu_d   = ltu_q;
    msb_a_d = msb_a_q;
    msb_b_d = msb_b_q;
    zf_d    = zf_q;
    sltu_d  = sltu_q;
    slt_d   = slt_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StRun;
          cnt_d   = '0;
          eq_d    = 1'b1;
          ltu_d   = 1'b0;
        end
      end
      StRun: begin
        if (bit_valid) begin
          cnt_d = cnt_q + CntW'(1);
          eq_d  = eq_new;
          ltu_d = ltu_new;
          if (cnt_q == '0) begin
            msb_a_d = a_bit;
            msb_b_d = b_bit;
          end
          if (cnt_q == LastBeat) begin
            zf_d    = eq_new;
            sltu_d  = ltu_new;
            // Differing sign bits decide the signed order outright.
            slt_d   = (msb_a_q != msb_b_q) ? msb_a_q : ltu_new;
            state_d = StDone;
          end
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      eq_q    <= 1'b1;
      ltu_q   <= 1'b0;
      msb_a_q <= 1'b0;
      msb_b_q <= 1'b0;
      zf_q    <= 1'b0;
      sltu_q  <= 1'b0;
      slt_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      eq_q    <= eq_d;
      ltu_q   <= ltu_d;
      msb_a_q <= msb_a_d;
      msb_b_q <= msb_b_d;
      zf_q    <= zf_d;
      sltu_q  <= sltu_d;
      slt_q   <= slt_d;
    end
  end

  assign busy = (state_q == StRun);
  assign done = (state_q == StDone);
  assign ZF   = zf_q;
  assign SLTu = sltu_q;
  assign SLT  = slt_q;

endmodule

// File: tb/tb_serial_comparator.sv
// Self-checking bench for serial_comparator at WIDTH=4 and WIDTH=8: spec vector table,
// hand-written corner sequences and randomized compares against an arithmetic model.
module tb_serial_comparator;

  logic clk = 1'b0;
  logic rst, start, bv, ab, bb, sel8;
  logic busy4, done4, zf4, sltu4, slt4;
  logic busy8, done8, zf8, sltu8, slt8;
  logic busy, done;
  logic [2:0] flags;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  serial_comparator #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst(rst), .start(start & ~sel8), .bit_valid(bv & ~sel8),
    .a_bit(ab), .b_bit(bb), .busy(busy4), .done(done4), .ZF(zf4), .SLTu(sltu4), .SLT(slt4)
  );

  serial_comparator #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .start(start & sel8), .bit_valid(bv & sel8),
    .a_bit(ab), .b_bit(bb), .busy(busy8), .done(done8), .ZF(zf8), .SLTu(sltu8), .SLT(slt8)
  );

  assign busy  = sel8 ? busy8 : busy4;
  assign done  = sel8 ? done8 : done4;
  assign flags = sel8 ? {zf8, sltu8, slt8} : {zf4, sltu4, slt4};

  typedef struct {
    logic       s8;
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] exp;  // {ZF, SLTu, SLT}
  } vec_t;

  vec_t tbl[7];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: plain integer comparison of the operands as unsigned and two's-complement.
  function automatic logic [2:0] ref_flags(input logic s8, input logic [7:0] a, input logic [7:0] b);
    int w, ua, ub, sa, sb;
    w  = s8 ? 8 : 4;
    ua = int'(a) & ((1 << w) - 1);
    ub = int'(b) & ((1 << w) - 1);
    sa = (ua >= (1 << (w - 1))) ? ua - (1 << w) : ua;
    sb = (ub >= (1 << (w - 1))) ? ub - (1 << w) : ub;
    return {ua == ub, ua < ub, sa < sb};
  endfunction

  // gap < 0 picks a random 0..3 idle cycles before each beat; poke pulses start mid-run and in DONE.
  task automatic run_cmp(input logic s8, input logic [7:0] a, input logic [7:0] b,
                         input logic [2:0] exp, input int gap, input bit poke);
    int w, g;
    w     = s8 ? 8 : 4;
    sel8  = s8;
    start = 1'b1;
    bv    = 1'b1;
    ab    = $urandom_range(0, 1);
    bb    = $urandom_range(0, 1);
    step();
    start = 1'b0;
    chk("busy_after_start", {7'd0, busy}, 8'd1);
    for (int i = 0; i < w; i++) begin
      g = (gap < 0) ? int'($urandom_range(0, 3)) : gap;
      for (int k = 0; k < g; k++) begin
        bv = 1'b0;
        ab = $urandom_range(0, 1);
        bb = $urandom_range(0, 1);
        step();
        chk("busy_gap", {7'd0, busy}, 8'd1);
        chk("done_gap", {7'd0, done}, 8'd0);
      end
      bv = 1'b1;
      ab = a[w-1-i];
      bb = b[w-1-i];
      if (poke && i == 2) start = 1'b1;
      step();
      start = 1'b0;
      if (i < w - 1) begin
        chk("busy_run", {7'd0, busy}, 8'd1);
        chk("done_early", {7'd0, done}, 8'd0);
      end
    end
    chk("done_pulse", {7'd0, done}, 8'd1);
    chk("busy_in_done", {7'd0, busy}, 8'd0);
    chk("flags", {5'd0, flags}, {5'd0, exp});
    bv    = 1'b0;
    start = poke;
    step();
    start = 1'b0;
    chk("done_one_cycle", {7'd0, done}, 8'd0);
    chk("no_restart", {7'd0, busy}, 8'd0);
    chk("flags_hold", {5'd0, flags}, {5'd0, exp});
  endtask

  initial begin
    logic [7:0] ra, rb;
    logic       rs8;
    logic [7:0] va, vb;

    tbl[0] = '{1'b0, 8'h07, 8'h0E, 3'b010};
    tbl[1] = '{1'b0, 8'h0E, 8'h07, 3'b001};
    tbl[2] = '{1'b0, 8'h03, 8'h06, 3'b011};
    tbl[3] = '{1'b0, 8'h06, 8'h03, 3'b000};
    tbl[4] = '{1'b1, 8'h80, 8'h7F, 3'b001};
    tbl[5] = '{1'b1, 8'hFF, 8'hFF, 3'b100};
    tbl[6] = '{1'b0, 8'h06, 8'h06, 3'b100};

    rst = 1'b1; start = 1'b0; bv = 1'b0; ab = 1'b0; bb = 1'b0; sel8 = 1'b0;
    step();
    step();
    rst = 1'b0;
    for (int s = 0; s < 2; s++) begin
      sel8 = s[0];
      #1;
      chk("rst_busy", {7'd0, busy}, 8'd0);
      chk("rst_done", {7'd0, done}, 8'd0);
      chk("rst_flags", {5'd0, flags}, 8'd0);
    end

    for (int i = 0; i < 7; i++) run_cmp(tbl[i].s8, tbl[i].a, tbl[i].b, tbl[i].exp, 0, 1'b0);

    // bit_valid activity in IDLE must be ignored; last WIDTH=4 result was A=6,B=6.
    sel8 = 1'b0;
    for (int i = 0; i < 6; i++) begin
      bv = $urandom_range(0, 1);
      ab = i[0];
      bb = ~i[0];
      step();
      chk("idle_busy", {7'd0, busy}, 8'd0);
      chk("idle_done", {7'd0, done}, 8'd0);
      chk("idle_flags", {5'd0, flags}, 8'b100);
    end
    bv = 1'b0;

    // Reset after beat 2 of A=7, B=E abandons the compare.
    va = 8'h07;
    vb = 8'h0E;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bv = 1'b1;
      ab = va[3-i];
      bb = vb[3-i];
      step();
    end
    rst = 1'b1;
    ab  = va[0];
    bb  = vb[0];
    step();
    rst = 1'b0;
    bv  = 1'b0;
    chk("midrst_busy", {7'd0, busy}, 8'd0);
    chk("midrst_done", {7'd0, done}, 8'd0);
    chk("midrst_flags", {5'd0, flags}, 8'd0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("midrst_no_done", {7'd0, done}, 8'd0);
    end
    run_cmp(1'b0, 8'h06, 8'h06, 3'b100, 0, 1'b0);

    run_cmp(1'b0, 8'h03, 8'h06, 3'b011, 3, 1'b0);
    run_cmp(1'b0, 8'h0E, 8'h07, 3'b001, 0, 1'b1);

    for (int i = 0; i < 40; i++) begin
      rs8 = i[0];
      ra  = $urandom_range(0, 255);
      rb  = ($urandom_range(0, 3) == 0) ? ra : 8'($urandom_range(0, 255));
      if (!rs8) begin
        ra = ra & 8'h0F;
        rb = rb & 8'h0F;
      end
      run_cmp(rs8, ra, rb, ref_flags(rs8, ra, rb), ($urandom_range(0, 1) == 1) ? -1 : 0,
              $urandom_range(0, 3) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
